// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - RV32I memory-access stage with MEM/WB pipeline register
//
// Optional build macro: SUBWORD_EN
//   defined   : Funct3M selects byte/half/word loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   undefined : word-only accesses, dmem_wstrb = 4'b1111, load data passed through as-is
//
// A load or store freezes the front of the pipe (StallM) while the single
// outstanding data-memory request is in flight. Once the memory answers, one
// more cycle runs with StallM low so the MEM/WB register captures the result,
// and the done flag keeps that same held instruction from being reissued.

module mem_wb_stage #(
   parameter int XLEN     = 32,
   parameter int MAX_WAIT = 15
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] ALUResultM,
   input  logic [XLEN-1:0] WriteDataM,
   input  logic [4:0]      RdM,
   input  logic [XLEN-1:0] ImmExtM,
   input  logic [XLEN-1:0] PCPlus4M,
   input  logic            RegWriteM,
   input  logic [1:0]      ResultSrcM,
   input  logic            MemWriteM,
   input  logic [2:0]      Funct3M,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [XLEN-1:0] dmem_wdata,
   output logic [3:0]      dmem_wstrb,
   input  logic            dmem_ready,
   input  logic [XLEN-1:0] dmem_rdata,
   output logic            StallM,
   output logic [XLEN-1:0] ResultW,
   output logic [4:0]      RdW,
   output logic            RegWriteW
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_BUSY = 1'b1;

   localparam int             WCW      = $clog2(MAX_WAIT + 1);
   localparam logic [WCW-1:0] WAIT_SAT = WCW'(MAX_WAIT);

   localparam logic [1:0] SRC_ALU  = 2'b00;
   localparam logic [1:0] SRC_LOAD = 2'b01;
   localparam logic [1:0] SRC_PC4  = 2'b10;
   localparam logic [1:0] SRC_IMM  = 2'b11;

   logic [0:0]      r_state;
   logic            r_done;
   logic [WCW-1:0]  r_wait_cnt;
   logic [XLEN-1:0] r_load_q;

   logic            w_access;
   logic            w_issue;
   logic [XLEN-1:0] w_aligned_addr;
   logic [XLEN-1:0] w_st_wdata;
   logic [3:0]      w_st_wstrb;
   logic [XLEN-1:0] w_ld_data;
   logic [XLEN-1:0] w_result;
   logic            w_unused;

   // A memory instruction is any store or any instruction whose result comes from memory.
   assign w_access       = MemWriteM | (ResultSrcM == SRC_LOAD);
   // Issue only once per held instruction: done blocks a second request.
   assign w_issue        = (r_state == S_IDLE) & w_access & ~r_done;
   assign StallM         = (r_state == S_BUSY) | w_issue;
   assign w_aligned_addr = {ALUResultM[XLEN-1:2], 2'b00};

`ifdef SUBWORD_EN
   logic [1:0] r_addr_lo;
   logic [2:0] r_funct3;
   logic [7:0]  w_ld_byte;
   logic [15:0] w_ld_half;

   // Remember byte offset and access type of the in-flight load for data formatting.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr_lo <= 2'b00;
         r_funct3  <= 3'b000;
      end else if (w_issue) begin
         r_addr_lo <= ALUResultM[1:0];
         r_funct3  <= Funct3M;
      end
   end

   // Store formatting: replicate the byte/half across the word and enable only its lanes.
   always_comb begin
      w_st_wdata = WriteDataM;
      w_st_wstrb = 4'b1111;
      case (Funct3M[1:0])
         2'b00: begin
            w_st_wdata = {(XLEN/8){WriteDataM[7:0]}};
            w_st_wstrb = 4'b0001 << ALUResultM[1:0];
         end
         2'b01: begin
            w_st_wdata = {(XLEN/16){WriteDataM[15:0]}};
            w_st_wstrb = 4'b0011 << {ALUResultM[1], 1'b0};
         end
         default: begin
            w_st_wdata = WriteDataM;
            w_st_wstrb = 4'b1111;
         end
      endcase
   end

   // Load formatting: pick the addressed byte/half (halves force-aligned) and extend it.
   always_comb begin
      w_ld_byte = dmem_rdata[7:0];
      case (r_addr_lo)
         2'b00:   w_ld_byte = dmem_rdata[7:0];
         2'b01:   w_ld_byte = dmem_rdata[15:8];
         2'b10:   w_ld_byte = dmem_rdata[23:16];
         default: w_ld_byte = dmem_rdata[31:24];
      endcase
      w_ld_half = r_addr_lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      case (r_funct3)
         3'b000:  w_ld_data = {{(XLEN-8){w_ld_byte[7]}}, w_ld_byte};
         3'b001:  w_ld_data = {{(XLEN-16){w_ld_half[15]}}, w_ld_half};
         3'b100:  w_ld_data = {{(XLEN-8){1'b0}}, w_ld_byte};
         3'b101:  w_ld_data = {{(XLEN-16){1'b0}}, w_ld_half};
         default: w_ld_data = dmem_rdata;
      endcase
   end

   // The wait counter is debug-only state.
   assign w_unused = &{1'b0, r_wait_cnt};
`else
   // Word-only build: full-word strobes and unformatted load data.
   assign w_st_wdata = WriteDataM;
   assign w_st_wstrb = 4'b1111;
   assign w_ld_data  = dmem_rdata;

   // Funct3M and the low address bits have no role without sub-word access; the wait counter is debug-only.
   assign w_unused = &{1'b0, Funct3M, ALUResultM[1:0], r_wait_cnt};
`endif

   // Request FSM: latch the access, hold the request until ready, then flag completion.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_done     <= 1'b0;
         r_wait_cnt <= '0;
         r_load_q   <= '0;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
         dmem_wstrb <= 4'b0000;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_issue) begin
                  dmem_req   <= 1'b1;
                  dmem_we    <= MemWriteM;
                  dmem_addr  <= w_aligned_addr;
                  dmem_wdata <= w_st_wdata;
                  dmem_wstrb <= w_st_wstrb;
                  r_wait_cnt <= '0;
                  r_state    <= S_BUSY;
               end else if (r_done) begin
                  // The MEM/WB register captures the result on this edge.
                  r_done <= 1'b0;
               end
            end
            S_BUSY: begin
               if (r_wait_cnt != WAIT_SAT) begin
                  r_wait_cnt <= r_wait_cnt + 1'b1;
               end
               if (dmem_ready) begin
                  r_load_q <= w_ld_data;
                  dmem_req <= 1'b0;
                  r_done   <= 1'b1;
                  r_state  <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Writeback source select.
   always_comb begin
      w_result = ALUResultM;
      case (ResultSrcM)
         SRC_ALU:  w_result = ALUResultM;
         SRC_LOAD: w_result = r_load_q;
         SRC_PC4:  w_result = PCPlus4M;
         SRC_IMM:  w_result = ImmExtM;
         default:  w_result = ALUResultM;
      endcase
   end

   // MEM/WB register: advance when not stalled, otherwise hold data and insert a bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ResultW   <= '0;
         RdW       <= 5'd0;
         RegWriteW <= 1'b0;
      end else if (!StallM) begin
         ResultW   <= w_result;
         RdW       <= RdM;
         RegWriteW <= RegWriteM & ~MemWriteM;
      end else begin
         RegWriteW <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - self-checking bench for mem_wb_stage

module tb_mem_wb_stage;

`ifdef SUBWORD_EN
   localparam bit SUB = 1'b1;
`else
   localparam bit SUB = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] ALUResultM = '0, WriteDataM = '0, ImmExtM = '0, PCPlus4M = '0;
   logic [4:0]  RdM = '0;
   logic        RegWriteM = 1'b0, MemWriteM = 1'b0;
   logic [1:0]  ResultSrcM = '0;
   logic [2:0]  Funct3M = '0;
   logic        dmem_req, dmem_we, dmem_ready = 1'b0, StallM, RegWriteW;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = '0, ResultW;
   logic [3:0]  dmem_wstrb;
   logic [4:0]  RdW;

   int checks = 0;
   int errors = 0;

   // observations of the last run_op
   int          ob_stalls, ob_reqs;
   logic [31:0] ob_addr, ob_wdata;
   logic        ob_we;
   logic [3:0]  ob_wstrb;
   bit          ob_bubble_bad, ob_hold_bad, ob_timeout;

   mem_wb_stage #(.XLEN(32), .MAX_WAIT(15)) dut (
      .clk(clk), .rst(rst),
      .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RdM(RdM), .ImmExtM(ImmExtM),
      .PCPlus4M(PCPlus4M), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
      .MemWriteM(MemWriteM), .Funct3M(Funct3M),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_ready(dmem_ready),
      .dmem_rdata(dmem_rdata), .StallM(StallM),
      .ResultW(ResultW), .RdW(RdW), .RegWriteW(RegWriteW)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic logic [31:0] m_load(logic [31:0] rd, logic [31:0] a, logic [2:0] f3);
      logic [7:0]  b;
      logic [15:0] h;
      b = 8'(rd >> (8 * int'(a[1:0])));
      h = 16'(rd >> (16 * int'(a[1])));
      if (!SUB) return rd;
      case (f3)
         3'd0:    return {{24{b[7]}}, b};
         3'd1:    return {{16{h[15]}}, h};
         3'd4:    return {24'd0, b};
         3'd5:    return {16'd0, h};
         default: return rd;
      endcase
   endfunction

   function automatic logic [31:0] m_wdata(logic [31:0] wd, logic [2:0] f3);
      if (SUB && f3[1:0] == 2'd0) return {4{wd[7:0]}};
      if (SUB && f3[1:0] == 2'd1) return {2{wd[15:0]}};
      return wd;
   endfunction

   function automatic logic [3:0] m_wstrb(logic [31:0] a, logic [2:0] f3);
      if (SUB && f3[1:0] == 2'd0) return 4'(1 << int'(a[1:0]));
      if (SUB && f3[1:0] == 2'd1) return 4'(3 << (2 * int'(a[1])));
      return 4'hF;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic set_op(logic [31:0] alu, logic [31:0] wd, logic [4:0] rd, logic [31:0] imm,
                         logic [31:0] pc4, logic rw, logic [1:0] src, logic mw, logic [2:0] f3);
      ALUResultM = alu; WriteDataM = wd; RdM = rd; ImmExtM = imm; PCPlus4M = pc4;
      RegWriteM = rw; ResultSrcM = src; MemWriteM = mw; Funct3M = f3;
   endtask

   // Runs the held instruction through the stage (called at a negedge); the memory
   // answers after `waits` busy cycles and random ready outside a request is noise.
   // Returns at the negedge after the MEM/WB register loaded.
   task automatic run_op(int waits, logic [31:0] rdata);
      int busy;
      logic prev_req, stall_now;
      logic [31:0] held_res;
      logic [4:0]  held_rd;
      busy = 0; prev_req = dmem_req; ob_stalls = 0; ob_reqs = 0;
      ob_bubble_bad = 0; ob_hold_bad = 0; ob_timeout = 1;
      ob_addr = 'x; ob_wdata = 'x; ob_we = 1'bx; ob_wstrb = 'x;
      held_res = ResultW; held_rd = RdW;
      for (int cyc = 0; cyc < 64; cyc++) begin
         #1;
         if (dmem_req && !prev_req) ob_reqs++;
         prev_req = dmem_req;
         if (dmem_req) begin
            ob_addr = dmem_addr; ob_wdata = dmem_wdata; ob_we = dmem_we; ob_wstrb = dmem_wstrb;
            dmem_ready = (busy == waits);
            dmem_rdata = (busy == waits) ? rdata : $urandom;
            busy++;
         end else begin
            dmem_ready = 1'($urandom_range(0, 1));
            dmem_rdata = $urandom;
         end
         stall_now = StallM;
         if (stall_now) begin
            ob_stalls++;
            if (ob_stalls == 1) begin
               held_res = ResultW; held_rd = RdW;
            end else begin
               if (RegWriteW !== 1'b0) ob_bubble_bad = 1;
               if (ResultW !== held_res || RdW !== held_rd) ob_hold_bad = 1;
            end
         end
         @(posedge clk);
         @(negedge clk);
         if (!stall_now) begin
            ob_timeout = 0;
            break;
         end
      end
      dmem_ready = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      rst = 1'b1;
      @(negedge clk); @(negedge clk);
      #1;
      checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", dmem_req); end
      checks++; if ({dmem_we, dmem_addr, dmem_wdata, dmem_wstrb} !== '0) begin errors++; $display("FAIL reset_dmem: got we=%b addr=%h wdata=%h wstrb=%h expected all 0", dmem_we, dmem_addr, dmem_wdata, dmem_wstrb); end
      checks++; if ({ResultW, RdW, RegWriteW} !== '0) begin errors++; $display("FAIL reset_w: got ResultW=%h RdW=%0d RegWriteW=%b expected 0", ResultW, RdW, RegWriteW); end
      checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", StallM); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_alu_op;
      set_op(32'h10, 32'h0, 5'd5, 32'h0, 32'h0, 1'b1, 2'b00, 1'b0, 3'd2);
      run_op(0, 32'h0);
      checks++; if (ob_stalls != 0) begin errors++; $display("FAIL alu_stall: got %0d stall cycles expected 0", ob_stalls); end
      checks++; if (ResultW !== 32'h10) begin errors++; $display("FAIL alu_result: got %h expected 00000010", ResultW); end
      checks++; if (RdW !== 5'd5 || RegWriteW !== 1'b1) begin errors++; $display("FAIL alu_rd: got RdW=%0d RegWriteW=%b expected 5 1", RdW, RegWriteW); end
   endtask

   task automatic test_load_wait;
      set_op(32'h104, 32'h0, 5'd9, 32'h0, 32'h0, 1'b1, 2'b01, 1'b0, 3'd2);
      run_op(2, 32'hDEADBEEF);
      checks++; if (ob_addr !== 32'h104) begin errors++; $display("FAIL load_addr: got %h expected 00000104", ob_addr); end
      checks++; if (ob_stalls != 4) begin errors++; $display("FAIL load_stall: got %0d expected 4", ob_stalls); end
      checks++; if (ob_reqs != 1 || ob_we !== 1'b0) begin errors++; $display("FAIL load_req: got reqs=%0d we=%b expected 1 0", ob_reqs, ob_we); end
      checks++; if (ob_bubble_bad || ob_hold_bad) begin errors++; $display("FAIL load_bubble: got bubble_bad=%0d hold_bad=%0d expected 0 0", ob_bubble_bad, ob_hold_bad); end
      checks++; if (ResultW !== 32'hDEADBEEF || RdW !== 5'd9 || RegWriteW !== 1'b1) begin errors++; $display("FAIL load_result: got %h rd=%0d rw=%b expected deadbeef 9 1", ResultW, RdW, RegWriteW); end
   endtask

   task automatic test_store;
      set_op(32'h200, 32'h12345678, 5'd7, 32'h0, 32'h0, 1'b1, 2'b00, 1'b1, 3'd2);
      run_op(0, 32'h0);
      checks++; if (ob_we !== 1'b1 || ob_wstrb !== 4'hF) begin errors++; $display("FAIL store_we: got we=%b wstrb=%b expected 1 1111", ob_we, ob_wstrb); end
      checks++; if (ob_addr !== 32'h200 || ob_wdata !== 32'h12345678) begin errors++; $display("FAIL store_data: got addr=%h wdata=%h expected 00000200 12345678", ob_addr, ob_wdata); end
      checks++; if (ob_stalls != 2) begin errors++; $display("FAIL store_stall: got %0d expected 2", ob_stalls); end
      checks++; if (RegWriteW !== 1'b0) begin errors++; $display("FAIL store_regwrite: got %b expected 0", RegWriteW); end
   endtask

   task automatic test_reset_busy;
      set_op(32'h300, 32'h0, 5'd3, 32'h0, 32'h0, 1'b1, 2'b01, 1'b0, 3'd2);
      dmem_ready = 1'b0;
      @(posedge clk); @(negedge clk); #1;
      checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL rstbusy_req_up: got %b expected 1", dmem_req); end
      rst = 1'b1;
      #1;
      checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL rstbusy_req: got %b expected 0", dmem_req); end
      checks++; if ({ResultW, RdW, RegWriteW} !== '0) begin errors++; $display("FAIL rstbusy_w: got ResultW=%h RdW=%0d RegWriteW=%b expected 0", ResultW, RdW, RegWriteW); end
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      run_op(1, 32'hCAFE0123);
      checks++; if (ob_reqs != 1 || ob_addr !== 32'h300) begin errors++; $display("FAIL rstbusy_reissue: got reqs=%0d addr=%h expected 1 00000300", ob_reqs, ob_addr); end
      checks++; if (ResultW !== 32'hCAFE0123 || RdW !== 5'd3) begin errors++; $display("FAIL rstbusy_result: got %h rd=%0d expected cafe0123 3", ResultW, RdW); end
   endtask

   task automatic test_subword;
      set_op(32'h103, 32'h0, 5'd4, 32'h0, 32'h0, 1'b1, 2'b01, 1'b0, 3'd0);
      run_op(0, 32'h80123456);
      checks++; if (ResultW !== m_load(32'h80123456, 32'h103, 3'd0)) begin errors++; $display("FAIL sub_lb: got %h expected %h", ResultW, m_load(32'h80123456, 32'h103, 3'd0)); end
      if (SUB) begin
         checks++; if (ResultW !== 32'hFFFFFF80) begin errors++; $display("FAIL sub_lb_const: got %h expected ffffff80", ResultW); end
      end
      set_op(32'h102, 32'h000000AB, 5'd0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b1, 3'd0);
      run_op(0, 32'h0);
      checks++; if (ob_wstrb !== m_wstrb(32'h102, 3'd0) || ob_wdata !== m_wdata(32'hAB, 3'd0)) begin errors++; $display("FAIL sub_sb: got wstrb=%b wdata=%h expected %b %h", ob_wstrb, ob_wdata, m_wstrb(32'h102, 3'd0), m_wdata(32'hAB, 3'd0)); end
      if (SUB) begin
         checks++; if (ob_wstrb !== 4'b0100 || ob_wdata !== 32'hABABABAB) begin errors++; $display("FAIL sub_sb_const: got wstrb=%b wdata=%h expected 0100 abababab", ob_wstrb, ob_wdata); end
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] a, rd;
      int w;
      for (int n = 0; n < 4; n++) begin
         a = $urandom; rd = $urandom; w = $urandom_range(0, 2);
         set_op(a, 32'h0, 5'(n + 10), 32'h0, 32'h0, 1'b1, 2'b01, 1'b0, 3'd2);
         run_op(w, rd);
         checks++; if (ob_reqs != 1 || ob_stalls != 2 + w) begin errors++; $display("FAIL b2b_req[%0d]: got reqs=%0d stalls=%0d expected 1 %0d", n, ob_reqs, ob_stalls, 2 + w); end
         checks++; if (ResultW !== m_load(rd, a, 3'd2) || RdW !== 5'(n + 10)) begin errors++; $display("FAIL b2b_result[%0d]: got %h rd=%0d expected %h %0d", n, ResultW, RdW, m_load(rd, a, 3'd2), n + 10); end
      end
      #1;
      checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL b2b_no_dup: got req=%b expected 0", dmem_req); end
   endtask

   task automatic test_random;
      logic [31:0] alu, wd, imm, pc4, rdata, exp_res;
      logic [4:0]  rd;
      logic [1:0]  src;
      logic        rw, mw, mem;
      logic [2:0]  f3;
      int kind, w;
      for (int n = 0; n < 40; n++) begin
         kind = $urandom_range(0, 3);
         alu = $urandom; wd = $urandom; imm = $urandom; pc4 = $urandom; rdata = $urandom;
         rd = 5'($urandom); rw = 1'($urandom); mw = 1'b0; f3 = 3'($urandom);
         w = $urandom_range(0, 4);
         case ($urandom_range(0, 2))
            0: src = 2'b00;
            1: src = 2'b10;
            default: src = 2'b11;
         endcase
         if (kind == 1) begin
            src = 2'b01;
            case ($urandom_range(0, 4))
               0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
            endcase
         end else if (kind == 2) begin
            mw = 1'b1; src = 2'b00; f3 = 3'($urandom_range(0, 2));
         end
         mem = (kind == 1) || (kind == 2);
         case (src)
            2'b00: exp_res = alu;
            2'b01: exp_res = m_load(rdata, alu, f3);
            2'b10: exp_res = pc4;
            default: exp_res = imm;
         endcase
         set_op(alu, wd, rd, imm, pc4, rw, src, mw, f3);
         run_op(w, rdata);
         checks++; if (ob_timeout) begin errors++; $display("FAIL rnd_timeout[%0d]: got stuck stalled, expected completion", n); end
         checks++; if (ob_stalls != (mem ? 2 + w : 0) || ob_reqs != (mem ? 1 : 0)) begin errors++; $display("FAIL rnd_stall[%0d]: got stalls=%0d reqs=%0d expected %0d %0d", n, ob_stalls, ob_reqs, mem ? 2 + w : 0, mem ? 1 : 0); end
         if (mem) begin
            checks++; if (ob_addr !== {alu[31:2], 2'b00} || ob_we !== mw) begin errors++; $display("FAIL rnd_addr[%0d]: got addr=%h we=%b expected %h %b", n, ob_addr, ob_we, {alu[31:2], 2'b00}, mw); end
         end
         if (mw) begin
            checks++; if (ob_wdata !== m_wdata(wd, f3) || ob_wstrb !== m_wstrb(alu, f3)) begin errors++; $display("FAIL rnd_store[%0d]: got wdata=%h wstrb=%b expected %h %b", n, ob_wdata, ob_wstrb, m_wdata(wd, f3), m_wstrb(alu, f3)); end
         end
         checks++; if (ob_bubble_bad || ob_hold_bad) begin errors++; $display("FAIL rnd_bubble[%0d]: got bubble_bad=%0d hold_bad=%0d expected 0 0", n, ob_bubble_bad, ob_hold_bad); end
         checks++; if (ResultW !== exp_res || RdW !== rd || RegWriteW !== (rw & ~mw)) begin errors++; $display("FAIL rnd_w[%0d]: got %h rd=%0d rw=%b expected %h %0d %b", n, ResultW, RdW, RegWriteW, exp_res, rd, rw & ~mw); end
      end
   endtask

   initial begin
      test_reset;
      test_alu_op;
      test_load_wait;
      test_store;
      test_reset_busy;
      test_subword;
      test_back_to_back;
      test_random;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
Memory-access stage plus MEM/WB pipeline register of the pipelined RV32I core. It consumes the EX/MEM register outputs, runs loads and stores against an external data memory over a req/ready handshake, and asserts StallM so the front of the pipe freezes while memory is busy. It selects the writeback result and registers ResultW/RdW/RegWriteW for the register file and forwarding unit.

Parameters:
XLEN, 32, datapath width; all data and address buses are XLEN bits.
MAX_WAIT, 15, width-sizing bound for the internal wait counter; no timeout action is taken.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
ALUResultM  input  XLEN  ALU result; the memory address for loads and stores
WriteDataM  input  XLEN  store data
RdM  input  5  destination register
ImmExtM  input  XLEN  extended immediate, used by lui
PCPlus4M  input  XLEN  return address
RegWriteM  input  1  register-write enable
ResultSrcM  input  2  00 ALU, 01 load, 10 PC+4, 11 immediate
MemWriteM  input  1  store enable
Funct3M  input  3  access size and sign; only used with SUBWORD_EN
dmem_req  output  1  registered memory request
dmem_we  output  1  1 = write
dmem_addr  output  XLEN  latched address
dmem_wdata  output  XLEN  latched write data
dmem_wstrb  output  4  byte strobes
dmem_ready  input  1  memory completes the request in this cycle
dmem_rdata  input  XLEN  read data, valid while dmem_ready = 1
StallM  output  1  combinational; freezes the PC, IF/ID, ID/EX and EX/MEM registers
ResultW  output  XLEN  registered writeback value
RdW  output  5  registered destination register
RegWriteW  output  1  registered write enable

Behaviour:
- Access detection: access = MemWriteM | (ResultSrcM == 01).
- State machine, states IDLE and BUSY. An internal done flag and a wait counter (wait_cnt) are also kept.
- IDLE with access = 1 and done = 0:
  - Latch address, data, strobes and write enable.
  - Set dmem_req to 1 and go to BUSY.
  - StallM = 1.
- BUSY: dmem_req stays 1 and StallM = 1.
  - On dmem_ready: capture the formatted read data into load_q, clear dmem_req, set done, return to IDLE.
  - dmem_ready is sampled only in BUSY; ready seen in IDLE is ignored.
- IDLE with done = 1: StallM = 0, the MEM/WB register loads, and done clears on this edge.
- StallM = (state == BUSY) | (state == IDLE & access & ~done).
- Latency: a non-memory op passes to W in 1 cycle. A memory op takes 3 + N cycles for N wait cycles in BUSY; a zero-wait memory gives 3 cycles.
- MEM/WB register:
  - When StallM = 0: RdW <= RdM, RegWriteW <= RegWriteM, ResultW <= mux(ResultSrcM: ALUResultM, load_q, PCPlus4M, ImmExtM).
  - When StallM = 1: insert a bubble, RegWriteW <= 0; RdW and ResultW hold.
- Stores never write the register file, regardless of RegWriteM.
- dmem_addr is word-aligned: {addr[XLEN-1:2], 2'b00}.
- Reset (asynchronous, at any time including mid-transaction): state IDLE, done = 0, dmem_req = 0, dmem_we = 0, dmem_addr = 0, dmem_wdata = 0, dmem_wstrb = 0, ResultW = 0, RdW = 0, RegWriteW = 0, wait_cnt = 0. An in-flight request is abandoned.
- wait_cnt counts cycles spent in BUSY, saturates at MAX_WAIT, and clears on entry to BUSY. It is for debug and has no functional effect.

Optional Feature:
SUBWORD_EN
- Defined:
  - Funct3M decodes LB/LH/LW/LBU/LHU and SB/SH/SW.
  - Stores replicate the byte or half across the word. Strobes are 0001 << addr[1:0] for bytes, 0011 << {addr[1], 0} for halves, 1111 for words.
  - Loads select the byte or half at the address and sign- or zero-extend it.
  - Misaligned halves and words are force-aligned down; no exception is raised.
- Not defined: Funct3M is ignored, dmem_wstrb = 1111, and load data passes through unmodified.

Test Plan:
1. ALU op, ResultSrcM = 00, ALUResultM = 0x0000_0010, RdM = 5, RegWriteM = 1 -> next cycle ResultW = 0x10, RdW = 5, RegWriteW = 1, StallM never asserted.
2. Load with ALUResultM = 0x104 and dmem_ready asserted 2 cycles after dmem_req rises, dmem_rdata = 0xDEAD_BEEF:
   - dmem_addr = 0x104 and StallM = 1 for 4 cycles.
   - Then ResultW = 0xDEADBEEF; RegWriteW = 0 during the stall.
3. Store with ALUResultM = 0x200 and WriteDataM = 0x1234_5678, zero-wait memory -> dmem_we = 1, dmem_wstrb = 1111, RegWriteW stays 0, StallM high for 2 cycles.
4. Assert rst while in BUSY -> dmem_req = 0 immediately, all W outputs 0; after release, the same held load reissues once.
5. SUBWORD_EN, LB at 0x103 with rdata = 0x80xx_xxxx -> ResultW = 0xFFFF_FF80. SB at 0x102 with data 0xAB -> wstrb = 0100, wdata = 0xABAB_ABAB.
6. Back-to-back loads -> each issues exactly one dmem_req; no duplicate request when done = 1.
